// File: rtl/digilock_pkg.sv
// DigiLock shared definitions: access-FSM state encoding
// and default timing constants.
package digilock_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ABERTO   = 2'b01,
    ERRO     = 2'b10,
    BLOQUEIO = 2'b11
  } estado_t;

  localparam int MAX_FALHAS_DEF = 3;
  localparam int T_ABERTA_DEF   = 50;
  localparam int T_BLOQUEIO_DEF = 200;
  localparam int CW_DEF         = 8;

endpackage

// File: rtl/contador_tempo.sv
// Loadable CW-bit down-counter; holds at zero, never wraps.
// Load takes priority over decrement.
module contador_tempo #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [CW-1:0] valor,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carga)
      cnt_d = valor;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_acesso.sv
// DigiLock access sequencer: open window, failure count,
// timed keypad lockout. Outputs are registered off next state.
module controle_acesso
  import digilock_pkg::*;
#(
  parameter int MAX_FALHAS = MAX_FALHAS_DEF,
  parameter int T_ABERTA   = T_ABERTA_DEF,
  parameter int T_BLOQUEIO = T_BLOQUEIO_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fim_verif,
  input  logic       senha_ok,
  output logic       trava_aberta,
  output logic       teclado_hab,
  output logic       bloqueado,
  output logic       cfg_permitido,
  output logic       erro,
  output logic [1:0] falhas
);

  localparam logic [1:0]    MAXF = 2'(MAX_FALHAS);
  localparam logic [CW-1:0] TA   = CW'(T_ABERTA - 1);
  localparam logic [CW-1:0] TB   = CW'(T_BLOQUEIO - 1);

  estado_t       est_q, est_d;
  logic [1:0]    falhas_q, falhas_d;
  logic [1:0]    n_falhas;
  logic          carga, dec, t_zero;
  logic [CW-1:0] valor;

  logic trava_q, tecl_q, bloq_q, cfg_q, erro_q;

  contador_tempo #(.CW(CW)) u_tempo (
    .clk   (clk),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .dec   (dec),
    .zero  (t_zero)
  );

  assign n_falhas = falhas_q + 2'd1;

  always_comb begin
    est_d    = est_q;
    falhas_d = falhas_q;
    carga    = 1'b0;
    valor    = '0;
    dec      = 1'b0;
    unique case (est_q)
      OCIOSO: begin
        if (fim_verif) begin
          if (senha_ok) begin
            est_d    = ABERTO;
            falhas_d = 2'd0;
            carga    = 1'b1;
            valor    = TA;
          end else if (n_falhas == MAXF) begin
            est_d    = BLOQUEIO;
            falhas_d = n_falhas;
            carga    = 1'b1;
            valor    = TB;
          end else begin
            est_d    = ERRO;
            falhas_d = n_falhas;
          end
        end
      end
      ERRO: est_d = OCIOSO;
      ABERTO: begin
        if (t_zero) est_d = OCIOSO;
        else        dec   = 1'b1;
      end
      BLOQUEIO: begin
        if (t_zero) begin
          est_d    = OCIOSO;
          falhas_d = 2'd0;
        end else begin
          dec = 1'b1;
        end
      end
      default: est_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      est_q    <= OCIOSO;
      falhas_q <= 2'd0;
      trava_q  <= 1'b0;
      tecl_q   <= 1'b1;
      bloq_q   <= 1'b0;
      cfg_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      est_q    <= est_d;
      falhas_q <= falhas_d;
      trava_q  <= (est_d == ABERTO);
      cfg_q    <= (est_d == ABERTO);
      erro_q   <= (est_d == ERRO);
      bloq_q   <= (est_d == BLOQUEIO);
      tecl_q   <= (est_d != BLOQUEIO);
    end
  end

  assign trava_aberta  = trava_q;
  assign teclado_hab   = tecl_q;
  assign bloqueado     = bloq_q;
  assign cfg_permitido = cfg_q;
  assign erro          = erro_q;
  assign falhas        = falhas_q;

endmodule

// File: tb/tb_controle_acesso.sv
// Bench for controle_acesso: window-count model checked every
// cycle, plus hand-computed spot checks.
module tb_controle_acesso;

  localparam int MAXF = 3;
  localparam int TA   = 4;
  localparam int TB   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fim_verif = 1'b0;
  logic       senha_ok = 1'b0;
  logic       trava_aberta, teclado_hab, bloqueado;
  logic       cfg_permitido, erro;
  logic [1:0] falhas;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  int cyc = 0;

  // model: remaining cycles of each window
  int m_open = 0;
  int m_lock = 0;
  bit m_erro = 1'b0;
  int m_falhas = 0;

  controle_acesso #(
    .MAX_FALHAS (MAXF),
    .T_ABERTA   (TA),
    .T_BLOQUEIO (TB),
    .CW         (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fim_verif     (fim_verif),
    .senha_ok      (senha_ok),
    .trava_aberta  (trava_aberta),
    .teclado_hab   (teclado_hab),
    .bloqueado     (bloqueado),
    .cfg_permitido (cfg_permitido),
    .erro          (erro),
    .falhas        (falhas)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_open = 0; m_lock = 0; m_erro = 0; m_falhas = 0;
    end else if (m_erro) begin
      m_erro = 0;
    end else if (m_open > 0) begin
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_falhas = 0;
    end else if (fim_verif) begin
      if (senha_ok) begin
        m_open = TA;
        m_falhas = 0;
      end else begin
        m_falhas = m_falhas + 1;
        if (m_falhas == MAXF) m_lock = TB;
        else m_erro = 1;
      end
    end
  end

  function automatic logic [6:0] model_vec();
    logic b;
    b = (m_lock > 0);
    return {m_open > 0, !b, b, m_open > 0, m_erro, 2'(m_falhas)};
  endfunction

  always @(negedge clk) begin
    logic [6:0] got, exp;
    if (run) begin
      got = {trava_aberta, teclado_hab, bloqueado, cfg_permitido,
             erro, falhas};
      exp = model_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic pulse(input logic ok);
    fim_verif = 1'b1;
    senha_ok  = ok;
    @(negedge clk);
    fim_verif = 1'b0;
    senha_ok  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    run = 1'b1;
    idle(1);
    // 1: reset state
    chk("rst_tecl", {3'b0, teclado_hab}, 4'h1);
    chk("rst_outs", {trava_aberta, bloqueado, cfg_permitido, erro}, 4'h0);
    chk("rst_falhas", {2'b0, falhas}, 4'h0);
    reset = 1'b0;
    idle(1);

    // 2: good password opens for TA cycles
    pulse(1'b1);
    chk("open_first", {2'b0, trava_aberta, cfg_permitido}, 4'h3);
    idle(TA - 1);
    chk("open_last", {3'b0, trava_aberta}, 4'h1);
    idle(1);
    chk("open_closed", {3'b0, trava_aberta}, 4'h0);

    // 3: bad, bad, good
    pulse(1'b0);
    chk("bad1", {1'b0, erro, falhas}, 4'h5);
    idle(1);
    chk("erro_width", {3'b0, erro}, 4'h0);
    pulse(1'b0);
    chk("bad2", {1'b0, erro, falhas}, 4'h6);
    pulse(1'b1);
    chk("ignored_in_erro", {2'b0, falhas}, 4'h2);
    pulse(1'b1);
    chk("good_clears", {1'b0, trava_aberta, falhas}, 4'h4);
    // 5: pulses during open window are ignored
    pulse(1'b0);
    pulse(1'b0);
    chk("open_ignore", {1'b0, trava_aberta, falhas}, 4'h4);
    idle(TA);

    // 4: three failures lock out for TB cycles
    pulse(1'b0); idle(1);
    pulse(1'b0); idle(1);
    pulse(1'b0);
    chk("lock_enter", {bloqueado, teclado_hab, falhas}, 4'hB);
    pulse(1'b1);
    pulse(1'b0);
    chk("lock_ignore", {bloqueado, teclado_hab, falhas}, 4'hB);
    idle(TB - 3);
    chk("lock_last", {3'b0, bloqueado}, 4'h1);
    idle(1);
    chk("lock_exit", {bloqueado, teclado_hab, falhas}, 4'h4);

    // 6: reset in third cycle of lockout
    pulse(1'b0); idle(1);
    pulse(1'b0); idle(1);
    pulse(1'b0);
    idle(2);
    chk("lock_mid", {3'b0, bloqueado}, 4'h1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_abort", {bloqueado, teclado_hab, falhas}, 4'h4);
    pulse(1'b1);
    chk("after_rst", {3'b0, trava_aberta}, 4'h1);
    idle(TA + 2);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
